// File: rtl/bus_bridge_pkg.sv
// Shared widths, access-size codes, channel state encodings and lane helpers
// for the instruction/data bus bridge.
package bus_bridge_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;
  localparam logic [1:0] MEM_SIZE_RSVD = 2'd3;

  localparam logic [1:0] BRIDGE_STATE_IDLE = 2'd0;
  localparam logic [1:0] BRIDGE_STATE_REQ  = 2'd1;
  localparam logic [1:0] BRIDGE_STATE_WAIT = 2'd2;

  function automatic logic [3:0] store_strb(input logic [1:0] off, input logic [1:0] size);
    logic [3:0] strb;
    strb = 4'b1111;
    case (size)
      MEM_SIZE_BYTE: strb = 4'b0001 << off;
      MEM_SIZE_HALF: strb = 4'b0011 << {off[1], 1'b0};
      MEM_SIZE_WORD, MEM_SIZE_RSVD: strb = 4'b1111;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic [BUS_DW-1:0] store_wdata(input logic [BUS_DW-1:0] value,
                                                    input logic [1:0] size);
    logic [BUS_DW-1:0] wd;
    wd = value;
    case (size)
      MEM_SIZE_BYTE: wd = {4{value[7:0]}};
      MEM_SIZE_HALF: wd = {2{value[15:0]}};
      default: wd = value;
    endcase
    return wd;
  endfunction

  // Misaligned half/word loads simply ignore the offset bits below their size.
  function automatic logic [BUS_DW-1:0] load_extend(input logic [BUS_DW-1:0] data,
                                                    input logic [1:0] off,
                                                    input logic [1:0] size,
                                                    input logic uns);
    logic [BUS_DW-1:0] sh;
    logic [BUS_DW-1:0] res;
    sh  = data;
    res = data;
    case (size)
      MEM_SIZE_BYTE: begin
        sh  = data >> {off, 3'b000};
        res = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      MEM_SIZE_HALF: begin
        sh  = data >> {off[1], 4'b0000};
        res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bus_channel_fsm.sv
// Request/response handshake sequencer shared by the instruction and data ports.
module bus_channel_fsm
  import bus_bridge_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic req_ready,
  input  logic resp_valid,
  output logic req_valid,
  output logic done,
  output logic start_take,
  output logic resp_take
);

  // state | meaning
  // IDLE  | no transaction, start pulse accepted
  // REQ   | req_valid high, fields held until ready
  // WAIT  | request accepted, waiting for resp_valid

  logic [1:0] state;
  logic [1:0] state_nxt;

  assign start_take = start && (state == BRIDGE_STATE_IDLE);
  assign resp_take  = resp_valid && (state == BRIDGE_STATE_WAIT);
  assign req_valid  = (state == BRIDGE_STATE_REQ);

  always_comb begin
    state_nxt = state;
    case (state)
      BRIDGE_STATE_IDLE: if (start) state_nxt = BRIDGE_STATE_REQ;
      BRIDGE_STATE_REQ:  if (req_ready) state_nxt = BRIDGE_STATE_WAIT;
      BRIDGE_STATE_WAIT: if (resp_valid) state_nxt = BRIDGE_STATE_IDLE;
      default:           state_nxt = BRIDGE_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= BRIDGE_STATE_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= resp_take;
    end
  end

endmodule

// File: rtl/bus_bridge.sv
// Core-side fetch/load/store pulses to two independent valid/ready bus ports,
// with byte-lane alignment and load extension.
module bus_bridge
  import bus_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_fetch,
  input  logic [BUS_AW-1:0] pc,
  output logic              inst_valid,
  output logic [BUS_DW-1:0] inst,
  input  logic              load_data,
  input  logic              store_data,
  input  logic [BUS_AW-1:0] data_addr,
  input  logic [BUS_DW-1:0] store_value,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  output logic              data_valid,
  output logic [BUS_DW-1:0] load_value,
  output logic              i_req_valid,
  input  logic              i_req_ready,
  output logic [BUS_AW-1:0] i_addr,
  input  logic              i_resp_valid,
  input  logic [BUS_DW-1:0] i_resp_data,
  output logic              d_req_valid,
  input  logic              d_req_ready,
  output logic              d_req_we,
  output logic [BUS_AW-1:0] d_addr,
  output logic [BUS_DW-1:0] d_wdata,
  output logic [3:0]        d_wstrb,
  input  logic              d_resp_valid,
  input  logic [BUS_DW-1:0] d_resp_data
);

  logic i_start_take;
  logic i_resp_take;
  logic d_start_take;
  logic d_resp_take;
  logic [1:0] ld_off;
  logic [1:0] ld_size;
  logic       ld_uns;
  logic       unused_pc_bits;

  assign unused_pc_bits = ^pc[1:0];

  bus_channel_fsm u_i_fsm (
    .clk        (clk),
    .rst        (rst),
    .start      (inst_fetch),
    .req_ready  (i_req_ready),
    .resp_valid (i_resp_valid),
    .req_valid  (i_req_valid),
    .done       (inst_valid),
    .start_take (i_start_take),
    .resp_take  (i_resp_take)
  );

  // A simultaneous load+store starts the data port once, as a store.
  bus_channel_fsm u_d_fsm (
    .clk        (clk),
    .rst        (rst),
    .start      (load_data | store_data),
    .req_ready  (d_req_ready),
    .resp_valid (d_resp_valid),
    .req_valid  (d_req_valid),
    .done       (data_valid),
    .start_take (d_start_take),
    .resp_take  (d_resp_take)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      i_addr <= '0;
      inst   <= '0;
    end else begin
      if (i_start_take) i_addr <= {pc[BUS_AW-1:2], 2'b00};
      if (i_resp_take) inst <= i_resp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      d_addr     <= '0;
      d_wdata    <= '0;
      d_wstrb    <= 4'b0000;
      d_req_we   <= 1'b0;
      ld_off     <= 2'b00;
      ld_size    <= MEM_SIZE_BYTE;
      ld_uns     <= 1'b0;
      load_value <= '0;
    end else begin
      if (d_start_take) begin
        d_addr   <= {data_addr[BUS_AW-1:2], 2'b00};
        d_req_we <= store_data;
        d_wstrb  <= store_data ? store_strb(data_addr[1:0], mem_size) : 4'b0000;
        d_wdata  <= store_data ? store_wdata(store_value, mem_size) : '0;
        ld_off   <= data_addr[1:0];
        ld_size  <= mem_size;
        ld_uns   <= mem_unsigned;
      end
      if (d_resp_take && !d_req_we)
        load_value <= load_extend(d_resp_data, ld_off, ld_size, ld_uns);
    end
  end

endmodule

// File: tb/tb_bus_bridge.sv
// Directed vector bench for bus_bridge: table of data accesses plus
// hand-written handshake, stall, overlap and reset sequences.
module tb_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_fetch;
  logic [31:0] pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic        load_data;
  logic        store_data;
  logic [31:0] data_addr;
  logic [31:0] store_value;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        data_valid;
  logic [31:0] load_value;
  logic        i_req_valid;
  logic        i_req_ready;
  logic [31:0] i_addr;
  logic        i_resp_valid;
  logic [31:0] i_resp_data;
  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_req_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] last_load = 32'h0;

  always #5 clk = ~clk;

  bus_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .inst_fetch   (inst_fetch),
    .pc           (pc),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .load_data    (load_data),
    .store_data   (store_data),
    .data_addr    (data_addr),
    .store_value  (store_value),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .data_valid   (data_valid),
    .load_value   (load_value),
    .i_req_valid  (i_req_valid),
    .i_req_ready  (i_req_ready),
    .i_addr       (i_addr),
    .i_resp_valid (i_resp_valid),
    .i_resp_data  (i_resp_data),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_req_we     (d_req_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_wstrb      (d_wstrb),
    .d_resp_valid (d_resp_valid),
    .d_resp_data  (d_resp_data)
  );

  typedef struct {
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] val;
    logic [31:0] resp;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_load;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic st, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] val,
                              input logic [31:0] resp, input logic [31:0] e_addr,
                              input logic [3:0] e_strb, input logic [31:0] e_wdata,
                              input logic [31:0] e_load);
    vec_t v;
    v.st = st; v.size = size; v.uns = uns; v.addr = addr; v.val = val; v.resp = resp;
    v.e_addr = e_addr; v.e_strb = e_strb; v.e_wdata = e_wdata; v.e_load = e_load;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    store_data   = v.st;
    load_data    = ~v.st;
    data_addr    = v.addr;
    store_value  = v.val;
    mem_size     = v.size;
    mem_unsigned = v.uns;
    tick();
    store_data = 1'b0;
    load_data  = 1'b0;
    data_addr  = 32'hFFFF_FFFF;
    chk("vec d_req_valid", {31'h0, d_req_valid}, 32'h1);
    chk("vec d_addr", d_addr, v.e_addr);
    chk("vec d_wstrb", {28'h0, d_wstrb}, {28'h0, v.e_strb});
    chk("vec d_wdata", d_wdata, v.e_wdata);
    chk("vec d_req_we", {31'h0, d_req_we}, {31'h0, v.st});
    d_req_ready = 1'b1;
    tick();
    d_req_ready  = 1'b0;
    d_resp_valid = 1'b1;
    d_resp_data  = v.resp;
    tick();
    d_resp_valid = 1'b0;
    if (!v.st) last_load = v.e_load;
    chk("vec data_valid", {31'h0, data_valid}, 32'h1);
    chk("vec load_value", load_value, last_load);
    tick();
    chk("vec data_valid pulse end", {31'h0, data_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] hold_addr, hold_wdata;
    logic [3:0]  hold_strb;
    int          pulses;

    rst = 1'b0; inst_fetch = 1'b0; pc = 32'h0; load_data = 1'b0; store_data = 1'b0;
    data_addr = 32'h0; store_value = 32'h0; mem_size = 2'd0; mem_unsigned = 1'b0;
    i_req_ready = 1'b0; i_resp_valid = 1'b0; i_resp_data = 32'h0;
    d_req_ready = 1'b0; d_resp_valid = 1'b0; d_resp_data = 32'h0;

    vecs[0] = mk(1'b1, 2'd0, 1'b0, 32'h203, 32'h12345678, 32'h0, 32'h200, 4'b1000, 32'h78787878, 32'h0);
    vecs[1] = mk(1'b1, 2'd1, 1'b0, 32'h406, 32'hCAFEBABE, 32'h0, 32'h404, 4'b1100, 32'hBABEBABE, 32'h0);
    vecs[2] = mk(1'b1, 2'd2, 1'b0, 32'h30C, 32'hDEADBEEF, 32'h0, 32'h30C, 4'b1111, 32'hDEADBEEF, 32'h0);
    vecs[3] = mk(1'b1, 2'd3, 1'b0, 32'h311, 32'h01020304, 32'h0, 32'h310, 4'b1111, 32'h01020304, 32'h0);
    vecs[4] = mk(1'b0, 2'd1, 1'b0, 32'h402, 32'h0, 32'h80010000, 32'h400, 4'b0000, 32'h0, 32'hFFFF8001);
    vecs[5] = mk(1'b0, 2'd1, 1'b1, 32'h402, 32'h0, 32'h80010000, 32'h400, 4'b0000, 32'h0, 32'h00008001);
    vecs[6] = mk(1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 32'h1234F600, 32'h100, 4'b0000, 32'h0, 32'hFFFFFFF6);
    vecs[7] = mk(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h9A000000, 32'h100, 4'b0000, 32'h0, 32'h0000009A);
    vecs[8] = mk(1'b0, 2'd2, 1'b0, 32'h502, 32'h0, 32'h87654321, 32'h500, 4'b0000, 32'h0, 32'h87654321);
    vecs[9] = mk(1'b1, 2'd1, 1'b0, 32'h001, 32'h00007FFF, 32'h0, 32'h000, 4'b0011, 32'h7FFF7FFF, 32'h0);

    tick(); tick();
    chk("reset i_req_valid", {31'h0, i_req_valid}, 32'h0);
    chk("reset d_req_valid", {31'h0, d_req_valid}, 32'h0);
    chk("reset outputs", {inst, load_value} == 64'h0 ? 32'h0 : 32'h1, 32'h0);
    chk("reset addrs", i_addr | d_addr | d_wdata | {28'h0, d_wstrb} | {31'h0, d_req_we}, 32'h0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Fetch with ready held high and the response two cycles after acceptance.
    i_req_ready = 1'b1;
    inst_fetch = 1'b1; pc = 32'h104;
    tick();
    inst_fetch = 1'b0; pc = 32'h0;
    chk("fetch i_req_valid", {31'h0, i_req_valid}, 32'h1);
    chk("fetch i_addr", i_addr, 32'h104);
    tick();
    chk("fetch req dropped", {31'h0, i_req_valid}, 32'h0);
    tick();
    i_resp_valid = 1'b1; i_resp_data = 32'h00500093;
    chk("fetch no early valid", {31'h0, inst_valid}, 32'h0);
    tick();
    i_resp_valid = 1'b0;
    chk("fetch inst_valid", {31'h0, inst_valid}, 32'h1);
    chk("fetch inst", inst, 32'h00500093);
    tick();
    chk("fetch inst_valid end", {31'h0, inst_valid}, 32'h0);
    i_req_ready = 1'b0;

    // Stalled store, with an ignored load pulse while busy.
    store_data = 1'b1; data_addr = 32'h22; store_value = 32'h55AA1234; mem_size = 2'd1;
    tick();
    store_data = 1'b0;
    hold_addr = d_addr; hold_wdata = d_wdata; hold_strb = d_wstrb;
    chk("stall d_addr", hold_addr, 32'h20);
    chk("stall d_wstrb", {28'h0, hold_strb}, 32'hC);
    chk("stall d_wdata", hold_wdata, 32'h12341234);
    for (int c = 0; c < 5; c++) begin
      load_data = (c == 2); data_addr = 32'h999; mem_size = 2'd0;
      tick();
      load_data = 1'b0;
      chk("stall hold", {d_req_valid, d_addr == hold_addr, d_wdata == hold_wdata,
                         d_wstrb == hold_strb} == 4'hF ? 32'h0 : 32'h1, 32'h0);
    end
    d_req_ready = 1'b1;
    tick();
    d_req_ready = 1'b0;
    chk("stall accepted", {31'h0, d_req_valid}, 32'h0);
    d_resp_valid = 1'b1; d_resp_data = 32'hAAAA5555;
    tick();
    d_resp_valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (data_valid) pulses++;
      if (d_req_valid) pulses += 10;
      tick();
    end
    chk("stall single transfer", pulses, 32'd1);
    chk("stall load_value kept", load_value, last_load);

    // Load and store together: only the store runs.
    load_data = 1'b1; store_data = 1'b1; data_addr = 32'h81; store_value = 32'h000000AB;
    mem_size = 2'd0; mem_unsigned = 1'b1;
    tick();
    load_data = 1'b0; store_data = 1'b0;
    chk("ldst we", {31'h0, d_req_we}, 32'h1);
    chk("ldst strb", {28'h0, d_wstrb}, 32'h2);
    chk("ldst wdata", d_wdata, 32'hABABABAB);
    d_req_ready = 1'b1; tick(); d_req_ready = 1'b0;
    d_resp_valid = 1'b1; d_resp_data = 32'h11223344; tick(); d_resp_valid = 1'b0;
    chk("ldst done", {31'h0, data_valid}, 32'h1);
    chk("ldst load_value kept", load_value, last_load);
    tick();

    // Fetch and load in the same cycle, data response first.
    inst_fetch = 1'b1; pc = 32'h200;
    load_data = 1'b1; data_addr = 32'h600; mem_size = 2'd2;
    tick();
    inst_fetch = 1'b0; load_data = 1'b0;
    chk("dual req", {30'h0, i_req_valid, d_req_valid}, 32'h3);
    i_req_ready = 1'b1; d_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0; d_req_ready = 1'b0;
    d_resp_valid = 1'b1; d_resp_data = 32'h0BADF00D;
    tick();
    d_resp_valid = 1'b0;
    last_load = 32'h0BADF00D;
    chk("dual data first", {30'h0, inst_valid, data_valid}, 32'h1);
    chk("dual load_value", load_value, last_load);
    i_resp_valid = 1'b1; i_resp_data = 32'hFEEDC0DE;
    tick();
    i_resp_valid = 1'b0;
    chk("dual inst second", {30'h0, inst_valid, data_valid}, 32'h2);
    chk("dual inst", inst, 32'hFEEDC0DE);
    tick();

    // Response with nothing outstanding.
    d_resp_valid = 1'b1; d_resp_data = 32'h12121212;
    tick();
    d_resp_valid = 1'b0;
    chk("idle resp ignored", {31'h0, data_valid}, 32'h0);
    chk("idle resp load_value", load_value, last_load);

    // Reset while waiting for a load response.
    load_data = 1'b1; data_addr = 32'h40; mem_size = 2'd2;
    tick();
    load_data = 1'b0;
    d_req_ready = 1'b1; tick(); d_req_ready = 1'b0;
    rst = 1'b0; tick(); rst = 1'b1;
    chk("rst load_value", load_value, 32'h0);
    d_resp_valid = 1'b1; d_resp_data = 32'h77777777;
    tick();
    d_resp_valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      if (data_valid || d_req_valid) pulses++;
      tick();
    end
    chk("rst no pulse", pulses, 32'd0);
    chk("rst load_value after", load_value, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_bridge.md
BUS_BRIDGE -- requirements
Module: bus_bridge

Interface
- REQ-001 No parameters; address and data widths are 32, taken from shared header macros.
- REQ-002 clk  in  1  clock, all logic on rising edge.
- REQ-003 rst  in  1  reset, synchronous, active-low.
- REQ-004 inst_fetch  in  1  one-cycle pulse, start instruction fetch.
- REQ-005 pc  in  32  fetch address, sampled with inst_fetch.
- REQ-006 inst_valid  out  1  one-cycle pulse, instruction available.
- REQ-007 inst  out  32  fetched instruction, held until next fetch response.
- REQ-008 load_data  in  1  one-cycle pulse, start load.
- REQ-009 store_data  in  1  one-cycle pulse, start store.
- REQ-010 data_addr  in  32  load/store byte address, sampled with start pulse.
- REQ-011 store_value  in  32  store operand (rs2), sampled with store_data.
- REQ-012 mem_size  in  2  0 byte, 1 half, 2 word, 3 reserved (treated as word).
- REQ-013 mem_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
- REQ-014 data_valid  out  1  one-cycle pulse, load or store complete.
- REQ-015 load_value  out  32  extended load result, held until next load completes.
- REQ-016 i_req_valid / i_req_ready  out/in  1/1  instruction request handshake.
- REQ-017 i_addr  out  32  instruction address, word-aligned.
- REQ-018 i_resp_valid / i_resp_data  in/in  1/32  instruction response, no back-pressure.
- REQ-019 d_req_valid / d_req_ready  out/in  1/1  data request handshake.
- REQ-020 d_req_we, d_addr, d_wdata, d_wstrb  out  1/32/32/4  write enable, word-aligned address, write data, byte strobes.
- REQ-021 d_resp_valid / d_resp_data  in/in  1/32  data response, no back-pressure.

Function
- REQ-022 Instruction and data ports each have an independent FSM, IDLE -> REQ -> WAIT -> IDLE, and may be busy simultaneously.
- REQ-023 IDLE -> REQ on start pulse; address and operands are registered, and req_valid rises the next cycle.
- REQ-024 REQ: req_valid and all request fields are held stable until the cycle with valid && ready, then the FSM goes to WAIT.
- REQ-025 WAIT: on resp_valid, capture the response, go to IDLE, and pulse inst_valid/data_valid exactly one cycle later; latency from accept to completion is at least 2 cycles.
- REQ-026 resp_valid in IDLE or REQ is ignored; start pulses while not IDLE are ignored.
- REQ-027 load_data and store_data asserted together: the store is executed and the load is dropped.
- REQ-028 i_addr/d_addr are the address with bits [1:0] cleared; misaligned half/word accesses silently drop the low address bits for their size.
- REQ-029 Store strobes: byte 4'b0001<<a[1:0]; half 4'b0011<<(2*a[1]); word 4'b1111.
- REQ-030 Store data: byte replicated ×4, half replicated ×2, word as-is; d_req_we=1 for stores, 0 for loads.
- REQ-031 Load: shift d_resp_data right by 8*a[1:0] (half: 16*a[1]), then extend per mem_size/mem_unsigned; load_value updates in the data_valid cycle.
- REQ-032 Store completion does not change load_value.
- REQ-033 inst updates in the inst_valid cycle.

Reset
- REQ-034 While rst=0, the next edge forces both FSMs to IDLE and drives req_valid, inst_valid, data_valid, d_req_we and d_wstrb to 0, and inst, load_value, i_addr, d_addr and d_wdata to 0.
- REQ-035 Reset mid-transaction abandons it; a later response is ignored and produces no pulse.

Structure
- REQ-036 The shared header holds the bus width macros, MEM_SIZE_* codes and BRIDGE_STATE_* encodings.
- REQ-037 One sub-module, bus_channel_fsm (the REQ/WAIT handshake), is instantiated twice; lane alignment stays in bus_bridge.

Verification
- REQ-038 Fetch pc=0x104 with i_req_ready=1 and response 0x00500093 two cycles later -> i_addr=0x104, a single inst_valid pulse, inst=0x00500093.
- REQ-039 Store byte at addr 0x203, value 0x12345678 -> d_addr=0x200, d_wstrb=4'b1000, d_wdata=0x78787878, d_req_we=1.
- REQ-040 Load half at addr 0x402 with resp 0x80010000 -> load_value=0xFFFF8001 when signed; 0x00008001 when unsigned.
- REQ-041 d_req_ready held low for 5 cycles -> d_req_valid, d_addr, d_wdata and d_wstrb remain constant, and a single transfer occurs.
- REQ-042 rst asserted in WAIT, then d_resp_valid arrives -> no data_valid pulse and the FSM stays IDLE.
- REQ-043 inst_fetch and load_data in the same cycle -> both ports issue requests, and each completion pulse follows its own response.
